// File: rtl/seg_mux_display.sv
// seg_mux_display: N-digit multiplexed 7-segment driver with tear-free double-buffered glyph banks.
// Latency: every output is registered, one clk behind the internal slot counter, digit index and active bank.
// Backpressure: none. A load strobe is always accepted and the newest staged load wins.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   digit_codes   : NUM_DIGITS packed 5-bit glyph codes, digit k = [k*5+4:k*5]
//   dp_in         : decimal point per digit, 1 = lit
//   blank_in      : 1 = digit forced dark
//   blink_in      : (SEG_BLINK_EN only) 1 = digit blinks at the frame-based blink rate
//   load          : one-cycle strobe that captures the inputs above into the staging bank
//   frame_done    : one-cycle pulse on the first output sample of each new scan
//   seg_selector  : active-low one-cold digit enable, bit k = digit k
//   segments      : active-low {a,b,c,d,e,f,g,dp}
// Optional feature macro: SEG_BLINK_EN (adds BLINK_FRAMES, blink_in and the blink phase logic).
module seg_mux_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 65536,
  parameter int DEAD_CYCLES  = 64,
  parameter int CODE_W       = 5
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS*CODE_W-1:0] digit_codes,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic [NUM_DIGITS-1:0]        blank_in,
  input  logic                         load,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]        blink_in,
`endif
  output logic                         frame_done,
  output logic [NUM_DIGITS-1:0]        seg_selector,
  output logic [7:0]                   segments
);

  localparam int CNT_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BANK_W = NUM_DIGITS * CODE_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Glyph ROM, active-low a..g. Codes 20..31 are dark.
  function automatic logic [6:0] glyph(input logic [CODE_W-1:0] code);
    case (code)
      5'd0:    glyph = 7'b0000001;
      5'd1:    glyph = 7'b1001111;
      5'd2:    glyph = 7'b0010010;
      5'd3:    glyph = 7'b0000110;
      5'd4:    glyph = 7'b1001100;
      5'd5:    glyph = 7'b0100100;
      5'd6:    glyph = 7'b0100000;
      5'd7:    glyph = 7'b0001111;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0000100;
      5'd10:   glyph = 7'b0001000;
      5'd11:   glyph = 7'b1100000;
      5'd12:   glyph = 7'b0110001;
      5'd13:   glyph = 7'b1000010;
      5'd14:   glyph = 7'b0110000;
      5'd15:   glyph = 7'b0111000;
      5'd16:   glyph = 7'b0011000;
      5'd17:   glyph = 7'b0100100;
      5'd18:   glyph = 7'b1111110;
      5'd19:   glyph = 7'b1000001;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;

  // Staging and active banks
  logic [BANK_W-1:0]     stg_codes_q, stg_codes_d, act_codes_q, act_codes_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;

  // Output registers
  logic                  wrap_q, wrap_d;
  logic                  fdone_q, fdone_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic              slot_end, boundary, in_dead, blink_dark;
  logic [CODE_W-1:0] cur_code;

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign cur_code = act_codes_q[idx_q*CODE_W +: CODE_W];

  // With zero dead time the comparison would be constant false, so drop it.
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt_q < CNT_W'(DEAD_CYCLES));
  end

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;

  assign blink_dark = phase_q & act_blink_q[idx_q];

  always_comb begin
    fcnt_d      = fcnt_q;
    phase_d     = phase_q;
    stg_blink_d = stg_blink_q;
    act_blink_d = act_blink_q;
    if (boundary) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
      if (pend_q) act_blink_d = stg_blink_q;
    end
    if (load) stg_blink_d = blink_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      phase_q     <= 1'b0;
      stg_blink_q <= '0;
      act_blink_q <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
      stg_blink_q <= stg_blink_d;
      act_blink_q <= act_blink_d;
    end
  end
`else
  assign blink_dark = 1'b0;
`endif

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    pend_d      = pend_q;
    stg_codes_d = stg_codes_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    act_codes_d = act_codes_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    // wrap_q marks the first cycle of a new frame; delaying it once more
    // lines frame_done up with the first output sample of that frame.
    wrap_d      = boundary;
    fdone_d     = wrap_q;
    sel_d       = '1;
    seg_d       = 8'hFF;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (boundary && pend_q) begin
      act_codes_d = stg_codes_q;
      act_dp_d    = stg_dp_q;
      act_blank_d = stg_blank_q;
      pend_d      = 1'b0;
    end

    // Placed after the swap so a load on the boundary cycle stays pending.
    if (load) begin
      stg_codes_d = digit_codes;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
      pend_d      = 1'b1;
    end

    if (!in_dead) begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!act_blank_q[idx_q] && !blink_dark) begin
        seg_d = {glyph(cur_code), ~act_dp_q[idx_q]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      stg_codes_q <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '1;
      act_codes_q <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      wrap_q      <= 1'b0;
      fdone_q     <= 1'b0;
      sel_q       <= '1;
      seg_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      stg_codes_q <= stg_codes_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      act_codes_q <= act_codes_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      wrap_q      <= wrap_d;
      fdone_q     <= fdone_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign frame_done   = fdone_q;
  assign seg_selector = sel_q;
  assign segments     = seg_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// Bench for seg_mux_display: 4 digits, 8-cycle slots, 2 dead cycles.
// Expected outputs come from the position within the frame (edge count since reset
// modulo the frame length) plus a two-bank model of staged and displayed content.
module tb_seg_mux_display;
  localparam int ND = 4;
  localparam int DC = 8;
  localparam int DD = 2;
  localparam int FR = ND * DC;
  localparam int BF = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic [ND*5-1:0] digit_codes = '0;
  logic [ND-1:0]   dp_in = '0;
  logic [ND-1:0]   blank_in = '0;
  logic [ND-1:0]   blink_in = '0;
  logic            frame_done;
  logic [ND-1:0]   seg_selector;
  logic [7:0]      segments;

  always #5 clk = ~clk;

  seg_mux_display #(
    .NUM_DIGITS(ND),
    .DIGIT_CYCLES(DC),
    .DEAD_CYCLES(DD),
    .CODE_W(5)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_codes(digit_codes),
    .dp_in(dp_in),
    .blank_in(blank_in),
    .load(load),
`ifdef SEG_BLINK_EN
    .blink_in(blink_in),
`endif
    .frame_done(frame_done),
    .seg_selector(seg_selector),
    .segments(segments)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;          // edges since reset release
  int last_pos = -1;  // frame position reflected by the outputs now (-1 while in reset)

  // Model banks
  logic [4:0]    s_code [ND];
  logic [4:0]    a_code [ND];
  logic [ND-1:0] s_dp, a_dp, s_bl, a_bl, s_bk, a_bk;
  bit            pend;

  function automatic logic [6:0] glyph7(input int c);
    case (c)
      0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
      9: return 7'b0000100;  10: return 7'b0001000;  11: return 7'b1100000;
     12: return 7'b0110001;  13: return 7'b1000010;  14: return 7'b0110000;
     15: return 7'b0111000;  16: return 7'b0011000;  17: return 7'b0100100;
     18: return 7'b1111110;  19: return 7'b1000001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (k=%0d pos=%0d): got %h, expected %h", nm, k, last_pos, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      s_code[i] = '0;
      a_code[i] = '0;
    end
    s_dp = '0; a_dp = '0;
    s_bl = '1; a_bl = '1;
    s_bk = '0; a_bk = '0;
    pend = 1'b0;
    k = 0;
    last_pos = -1;
  endtask

  // Wait for the next edge to settle, compare against the model, then advance
  // the model through that edge using the inputs that were presented to it.
  task automatic step();
    int pos, slot, c, phase;
    logic [ND-1:0] e_sel;
    logic [7:0]    e_seg;
    logic          e_fd;
    @(negedge clk);
    if (rst) begin
      cmp("reset_sel", 32'(seg_selector), 32'hF);
      cmp("reset_seg", 32'(segments), 32'hFF);
      cmp("reset_fd", 32'(frame_done), 32'h0);
      model_reset();
    end else begin
      pos   = k % FR;
      slot  = pos / DC;
      c     = pos % DC;
      phase = 0;
`ifdef SEG_BLINK_EN
      phase = ((k / FR) / BF) % 2;
`endif
      e_fd = (k > 0) && (pos == 0);
      if (c < DD) begin
        e_sel = '1;
        e_seg = 8'hFF;
      end else begin
        e_sel = ~(ND'(1) << slot);
        if (a_bl[slot] || (phase == 1 && a_bk[slot]))
          e_seg = 8'hFF;
        else
          e_seg = {glyph7(int'(a_code[slot])), ~a_dp[slot]};
      end
      last_pos = pos;
      cmp("model_sel", 32'(seg_selector), 32'(e_sel));
      cmp("model_seg", 32'(segments), 32'(e_seg));
      cmp("model_fd", 32'(frame_done), 32'(e_fd));
      if (pos == FR - 1 && pend) begin
        a_code = s_code;
        a_dp = s_dp; a_bl = s_bl; a_bk = s_bk;
        pend = 1'b0;
      end
      if (load) begin
        for (int i = 0; i < ND; i++) s_code[i] = digit_codes[i*5 +: 5];
        s_dp = dp_in; s_bl = blank_in; s_bk = blink_in;
        pend = 1'b1;
      end
      k++;
    end
  endtask

  // Advance to the next occurrence of frame position p (bounded).
  task automatic run_to(input int p);
    step();
    for (int i = 0; i < 2 * FR && last_pos != p; i++) step();
    cmp("run_to_reached", 32'(last_pos), 32'(p));
  endtask

  task automatic do_load(input logic [ND*5-1:0] codes, input logic [ND-1:0] dp,
                         input logic [ND-1:0] bl);
    digit_codes = codes;
    dp_in = dp;
    blank_in = bl;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Idle after reset: dark, dead time then digit 0 selected, frame_done per frame
    step();
    cmp("lit_idle_sel0", 32'(seg_selector), 32'hF);
    cmp("lit_idle_seg0", 32'(segments), 32'hFF);
    step(); step();
    cmp("lit_idle_sel2", 32'(seg_selector), 32'hE);
    cmp("lit_idle_seg2", 32'(segments), 32'hFF);
    run_to(0);
    cmp("lit_fd_frame", 32'(frame_done), 32'h1);

    // Mid-frame load is held until the boundary
    run_to(12);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000);
    run_to(18);
    cmp("lit_hold_old", 32'(segments), 32'hFF);
    run_to(2);  cmp("lit_d0_seg", 32'(segments), 32'h03); cmp("lit_d0_sel", 32'(seg_selector), 32'hE);
    run_to(10); cmp("lit_d1_seg", 32'(segments), 32'h9F); cmp("lit_d1_sel", 32'(seg_selector), 32'hD);
    run_to(18); cmp("lit_d2_seg", 32'(segments), 32'h25); cmp("lit_d2_sel", 32'(seg_selector), 32'hB);
    run_to(26); cmp("lit_d3_seg", 32'(segments), 32'h0D); cmp("lit_d3_sel", 32'(seg_selector), 32'h7);

    // Two loads in one frame: the last one wins
    run_to(5);
    do_load({5'd3, 5'd2, 5'd1, 5'd8}, 4'b0000, 4'b0000);
    run_to(20);
    do_load({5'd3, 5'd2, 5'd1, 5'd16}, 4'b0000, 4'b0000);
    run_to(2);
    cmp("lit_last_load", 32'(segments), 32'h31);

    // Load on the boundary cycle waits a full extra frame
    run_to(30);
    do_load({5'd3, 5'd2, 5'd1, 5'd5}, 4'b0000, 4'b0000);
    step();
    cmp("lit_bnd_fd", 32'(frame_done), 32'h1);
    run_to(2);
    cmp("lit_bnd_old", 32'(segments), 32'h31);
    run_to(2);
    cmp("lit_bnd_new", 32'(segments), 32'h49);

    // Blank and decimal point
    run_to(3);
    do_load({4{5'd18}}, 4'b0001, 4'b0100);
    run_to(2);  cmp("lit_dp_on", 32'(segments), 32'hFC);
    run_to(10); cmp("lit_dp_off", 32'(segments), 32'hFD);
    run_to(18); cmp("lit_blank_seg", 32'(segments), 32'hFF); cmp("lit_blank_sel", 32'(seg_selector), 32'hB);
    run_to(26); cmp("lit_dash", 32'(segments), 32'hFD);

    // Reset mid-scan discards a pending load
    run_to(7);
    do_load({5'd0, 5'd0, 5'd0, 5'd8}, 4'b0000, 4'b0000);
    run_to(12);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    run_to(2);
    run_to(2);
    cmp("lit_rst_dark", 32'(segments), 32'hFF);

    // Randomized traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 599) == 0);
      load = ($urandom_range(0, 5) == 0);
      if (load) begin
        for (int i = 0; i < ND; i++) digit_codes[i*5 +: 5] = 5'($urandom_range(0, 31));
        dp_in    = ND'($urandom);
        blank_in = ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0;
`ifdef SEG_BLINK_EN
        blink_in = ND'($urandom);
`endif
      end
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
